// File: rtl/fsm_sym_pkg.sv
// Shared types and constants for the FSM symbol feeder.
package fsm_sym_pkg;

  // One symbol as driven onto the FSM inputs: {in1, in0}.
  typedef logic [1:0] sym_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

  localparam int   SYMS_PER_BYTE = 4;
  localparam sym_t DEF_IDLE_SYM  = 2'b00;

  // Symbol k of a byte; the LSB pair is symbol 0.
  function automatic sym_t byte_sym(input logic [7:0] b, input logic [1:0] k);
    return b[{k, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/fsm_sym_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with sync clear; pointers wrap modulo DEPTH.
module fsm_sym_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsm_sym_feeder.sv
// Byte-to-symbol feeder: buffers bytes and shifts them out as 2-bit symbols
// onto the in0/in1 inputs of a 2-input control FSM.
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready.
// s_valid may be raised at any time and s_data must be stable while it is up;
// s_ready depends only on registered occupancy and on rst/clr, never on s_valid.
module fsm_sym_feeder
  import fsm_sym_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter sym_t IDLE_SYM = DEF_IDLE_SYM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   in0,
  output logic                   in1,
  output logic                   sym_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output shift_state_t           dbg_state
);

  localparam logic [1:0] LAST_IDX = 2'(SYMS_PER_BYTE - 1);

  logic         flush;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [7:0]   head;

  shift_state_t state, state_n;
  logic [1:0]   idx, idx_n;
  logic [7:0]   shreg, shreg_n;
  sym_t         sym_q, sym_n;
  logic         vld_q, vld_n;

  assign flush   = rst || clr;
  assign s_ready = !rst && !clr && !full;
  assign push    = s_valid && s_ready;

  fsm_sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  // Shifter next state: load a byte from the FIFO head, step through its
  // symbols while enabled, chain straight into the next byte at the last one.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shreg_n = shreg;
    sym_n   = sym_q;
    vld_n   = vld_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          shreg_n = head;
          idx_n   = 2'd0;
          sym_n   = byte_sym(head, 2'd0);
          vld_n   = 1'b1;
          state_n = SHIFT;
        end else begin
          sym_n = IDLE_SYM;
          vld_n = 1'b0;
        end
      end
      SHIFT: begin
        if (en) begin
          if (idx != LAST_IDX) begin
            idx_n = idx + 2'd1;
            sym_n = byte_sym(shreg, idx + 2'd1);
          end else if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            idx_n   = 2'd0;
            sym_n   = byte_sym(head, 2'd0);
          end else begin
            sym_n   = IDLE_SYM;
            vld_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        sym_n   = IDLE_SYM;
        vld_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Shifter state and registered symbol outputs; rst and clr drop any partial byte.
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
      idx   <= 2'd0;
      shreg <= 8'h00;
      sym_q <= IDLE_SYM;
      vld_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      sym_q <= sym_n;
      vld_q <= vld_n;
    end
  end

  assign in0       = sym_q[0];
  assign in1       = sym_q[1];
  assign sym_valid = vld_q;
  assign busy      = vld_q || (level != '0);
  assign dbg_state = state;

endmodule

// File: doc/fsm_sym_feeder.md
# fsm_sym_feeder

Upstream stimulus stage for the 2-input control FSM netlists (e.g. `c1126`). It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialised into four 2-bit symbols driven onto the FSM's `in0`/`in1` inputs, one per enabled cycle. When no data is pending, the outputs return to a fixed idle symbol, so the FSM always sees defined inputs.

## Interface
- `DEPTH`, 4: byte FIFO entries; power of 2, ≥2.
- `IDLE_SYM`, 2'b00: `{in1,in0}` value driven when no symbol is valid.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous flush; same effect as `rst` on data path state.
- `en`  in  1  step enable; the shifter loads/advances only when `en`=1.
- `s_data`  in  8  byte to serialise.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  byte accepted on an edge where `s_valid`&`s_ready`.
- `in0`  out  1  symbol bit 0, drives the FSM `in0`.
- `in1`  out  1  symbol bit 1, drives the FSM `in1`.
- `sym_valid`  out  1  `in0`/`in1` carry a data symbol, not idle.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the byte in the shifter.
- `busy`  out  1  `sym_valid` | (`level`≠0).

## Operation
- Symbol k of a byte (k=0..3): `in0`=byte[2k], `in1`=byte[2k+1]. LSB pair is sent first.
- `s_ready` = !`rst` & !`clr` & (`level`≠`DEPTH`). It is combinational from registered count and has no bypass.
- Shifter FSM has states IDLE and SHIFT, plus a 2-bit index `idx`.
  - IDLE, `en`=1, FIFO non-empty: pop a byte, enter SHIFT, drive symbol 0, set `idx`=0, `sym_valid`=1.
  - IDLE, otherwise: outputs = `IDLE_SYM`, `sym_valid`=0.
  - SHIFT, `en`=0: hold the current symbol, `idx` and state.
  - SHIFT, `en`=1, `idx`<3: advance to symbol `idx`+1.
  - SHIFT, `en`=1, `idx`=3, FIFO non-empty: pop and drive symbol 0 of the next byte (no bubble).
  - SHIFT, `en`=1, `idx`=3, FIFO empty: go to IDLE; outputs = `IDLE_SYM`, `sym_valid`=0.
- Push and pop on the same edge are both honoured; `level` is unchanged.
- `rst` or `clr`: FIFO emptied, shifter set to IDLE, any partial byte is dropped. A push presented in that cycle is not accepted because `s_ready`=0. `clr` has priority over `en` and push.
- Reset values: `in0`=`IDLE_SYM`[0], `in1`=`IDLE_SYM`[1], `sym_valid`=0, `level`=0, `busy`=0, `s_ready`=0 while `rst`=1 and 1 on the first cycle after.

## Timing
- `in0`, `in1` and `sym_valid` are registered outputs.
- Latency, with the FIFO empty, shifter IDLE and `en`=1: a byte is accepted at edge E0 and symbol 0 is visible after edge E1. That is two cycles from the accept cycle to the first symbol.
- Throughput is one symbol per enabled cycle. A full FIFO drains at 4·`DEPTH` symbols with no gaps.
- `level` updates on the edge of the push or pop. `s_ready` rises in the cycle after the pop that frees a full FIFO.
- `busy` is combinational from registered state.

## Structure
- Package `fsm_sym_pkg` contains:
  - `sym_t` (2-bit, `{in1,in0}`).
  - `shift_state_t` enum (IDLE, SHIFT).
  - Constant `SYMS_PER_BYTE`=4.
  - Default `IDLE_SYM`.
- Sub-module `fsm_sym_fifo`: synchronous `DEPTH`×8 FIFO with push, pop, full, empty, count and sync clear. Pointers wrap modulo `DEPTH`, and count is one bit wider than the pointers.
- The top level holds the shifter FSM, output registers and handshake logic.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `in0`=`in1`=0, `sym_valid`=0, `level`=0, `s_ready`=0. On the first cycle after reset, `s_ready`=1.
- **Single byte:** push 0xE4 with `en`=1 → `{in1,in0}` = 00, 01, 10, 11 on four consecutive cycles, starting 2 cycles after accept. Then `sym_valid`=0, `busy`=0.
- **Full FIFO:** with `en`=0, offer 5 bytes 0x00, 0xFF, 0x1B, 0xE4, 0x55 → 4 accepted, `s_ready`=0, `level`=4. Raise `en` → 16 gap-free symbols in order, and the 5th byte is accepted one cycle after the first pop.
- **Stall mid-byte:** push 0x1B, drop `en` after symbol 1 (10) for 3 cycles → 10 held with `sym_valid`=1. Then 01, 00 follow.
- **Flush:** pulse `clr` during symbol 2 of 0xE4 with 2 bytes queued → next cycle idle, `level`=0, remaining symbols dropped. A push offered during `clr` is not accepted.
- **Back-to-back:** push 0x00 and 0xFF on consecutive cycles → 8 symbols with no idle cycle between bytes.
